// File: rtl/ste_joypad_scanner.sv
// ste_joypad_scanner
// Scans an Atari STE enhanced joypad port. The four active-low row selects
// (pins 1-4) are driven one at a time. Each row is held for SETTLE cycles and
// the synchronized pad pins (11-14, 6, 10) are captured into a scan buffer on
// the last cycle of the row. After the fourth row a single DONE cycle
// publishes the scan as the raw matrix and as the decoded 16-bit pad state.
//
// Optional build macro: STE_PAD_DEBOUNCE_EN
//   When it is defined, a scan is published only if it is identical to the
//   previous full scan. A previous-scan register holds that scan and is
//   loaded on every DONE.
//
// Handshake: valid is a one-cycle strobe with no ready. It is high exactly in
// the cycle in which matrix and joy first show a new scan, which is the cycle
// after DONE. There is no back-pressure, and nothing is held for a consumer.
module ste_joypad_scanner #(
  parameter int SETTLE = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [3:0]  pad_data,
  input  logic [1:0]  pad_btn,
  output logic [3:0]  sel,
  output logic [23:0] matrix,
  output logic [15:0] joy,
  output logic        valid,
  output logic        busy,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ROW0 = 3'd1,
    ST_ROW1 = 3'd2,
    ST_ROW2 = 3'd3,
    ST_ROW3 = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  localparam logic [7:0] LAST_CNT = 8'(SETTLE - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [5:0]  sync1_q, sync1_d;
  logic [5:0]  sync2_q, sync2_d;
  logic [23:0] scan_q, scan_d;
  logic [23:0] matrix_q, matrix_d;
  logic [15:0] joy_q, joy_d;
  logic        valid_q, valid_d;
`ifdef STE_PAD_DEBOUNCE_EN
  logic [23:0] prev_q, prev_d;
`endif

  logic [5:0]  pins_act;
  logic [1:0]  row_idx;
  logic [3:0]  row_sel;
  state_t      row_next;
  logic [15:0] joy_dec;

  // Two-flop synchronizer for the asynchronous pad pins, then active-high view
  always_comb begin
    sync1_d  = {pad_btn, pad_data};
    sync2_d  = sync1_q;
    pins_act = ~sync2_q;
  end

  // Per-row lookup: buffer slot, select pattern and the state that follows
  always_comb begin
    row_idx  = 2'd0;
    row_sel  = 4'hF;
    row_next = ST_IDLE;
    case (state_q)
      ST_ROW0: begin row_idx = 2'd0; row_sel = 4'b1110; row_next = ST_ROW1; end
      ST_ROW1: begin row_idx = 2'd1; row_sel = 4'b1101; row_next = ST_ROW2; end
      ST_ROW2: begin row_idx = 2'd2; row_sel = 4'b1011; row_next = ST_ROW3; end
      ST_ROW3: begin row_idx = 2'd3; row_sel = 4'b0111; row_next = ST_DONE; end
      default: begin row_idx = 2'd0; row_sel = 4'hF;    row_next = ST_IDLE; end
    endcase
  end

  // Decode the scan buffer into pad bits.
  // Each row occupies 6 bits of the buffer, {btn1, btn0, data3..data0}.
  assign joy_dec = {2'b00,
                    scan_q[4],  scan_q[7],  scan_q[20], scan_q[8],
                    scan_q[13], scan_q[19], scan_q[23], scan_q[17],
                    scan_q[11], scan_q[5],  scan_q[0],  scan_q[1],
                    scan_q[2],  scan_q[3]};

  // Scan FSM: next state, row timing, sampling and publication of results
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    scan_d   = scan_q;
    matrix_d = matrix_q;
    joy_d    = joy_q;
    valid_d  = 1'b0;
`ifdef STE_PAD_DEBOUNCE_EN
    prev_d   = prev_q;
`endif
    sel      = 4'hF;
    busy     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (enable) state_d = ST_ROW0;
      end
      ST_ROW0, ST_ROW1, ST_ROW2, ST_ROW3: begin
        busy = 1'b1;
        sel  = row_sel;
        if (cnt_q == LAST_CNT) begin
          cnt_d = '0;
          case (row_idx)
            2'd0:    scan_d[5:0]   = pins_act;
            2'd1:    scan_d[11:6]  = pins_act;
            2'd2:    scan_d[17:12] = pins_act;
            default: scan_d[23:18] = pins_act;
          endcase
          state_d = row_next;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_DONE: begin
        busy  = 1'b1;
        cnt_d = '0;
`ifdef STE_PAD_DEBOUNCE_EN
        prev_d = scan_q;
        if (scan_q == prev_q) begin
          matrix_d = scan_q;
          joy_d    = joy_dec;
          valid_d  = 1'b1;
        end
`else
        matrix_d = scan_q;
        joy_d    = joy_dec;
        valid_d  = 1'b1;
`endif
        state_d = enable ? ST_ROW0 : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and data registers; reset clears everything at once, mid-scan included
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      sync1_q  <= '0;
      sync2_q  <= '0;
      scan_q   <= '0;
      matrix_q <= '0;
      joy_q    <= '0;
      valid_q  <= 1'b0;
`ifdef STE_PAD_DEBOUNCE_EN
      prev_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      scan_q   <= scan_d;
      matrix_q <= matrix_d;
      joy_q    <= joy_d;
      valid_q  <= valid_d;
`ifdef STE_PAD_DEBOUNCE_EN
      prev_q   <= prev_d;
`endif
    end
  end

  assign matrix    = matrix_q;
  assign joy       = joy_q;
  assign valid     = valid_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ste_joypad_scanner.sv
// Bench for ste_joypad_scanner with SETTLE=4 and a joypad model.
// The model drives the pad pins from sel and from a table of pressed keys.
module tb_ste_joypad_scanner;

  localparam int S = 4;
  localparam int P = 4 * S + 1;

  logic        clk, reset_n, enable;
  logic [3:0]  pad_data;
  logic [1:0]  pad_btn;
  logic [3:0]  sel;
  logic [23:0] matrix;
  logic [15:0] joy;
  logic        valid, busy;
  logic [2:0]  dbg_state;

  // pressed keys, active-high, row r at [6r+5:6r] = {btn1, btn0, data3..0}
  logic [23:0] press;
  int n_cmp, n_bad;

  ste_joypad_scanner #(.SETTLE(S)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .pad_data(pad_data), .pad_btn(pad_btn),
    .sel(sel), .matrix(matrix), .joy(joy), .valid(valid), .busy(busy),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // joypad model: pulls the pins of pressed keys low only while their row is selected
  always_comb begin
    {pad_btn, pad_data} = 6'h3F;
    case (sel)
      4'b1110: {pad_btn, pad_data} = ~press[5:0];
      4'b1101: {pad_btn, pad_data} = ~press[11:6];
      4'b1011: {pad_btn, pad_data} = ~press[17:12];
      4'b0111: {pad_btn, pad_data} = ~press[23:18];
      default: {pad_btn, pad_data} = 6'h3F;
    endcase
  end

  // reference: each joy bit is one (row, pin) position of the key matrix
  function automatic logic [15:0] model_joy(input logic [23:0] m);
    logic [15:0] j;
    int r, p;
    j = '0;
    for (int b = 0; b < 14; b++) begin
      r = 0; p = 0;
      case (b)
        0:  begin r = 0; p = 3; end
        1:  begin r = 0; p = 2; end
        2:  begin r = 0; p = 1; end
        3:  begin r = 0; p = 0; end
        4:  begin r = 0; p = 5; end
        5:  begin r = 1; p = 5; end
        6:  begin r = 2; p = 5; end
        7:  begin r = 3; p = 5; end
        8:  begin r = 3; p = 1; end
        9:  begin r = 2; p = 1; end
        10: begin r = 1; p = 2; end
        11: begin r = 3; p = 2; end
        12: begin r = 1; p = 1; end
        default: begin r = 0; p = 4; end
      endcase
      j[b] = m[6 * r + p];
    end
    return j;
  endfunction

  function automatic logic [3:0] model_sel(input int m);
    int row;
    row = m / S;
    if (row >= 4) return 4'hF;
    return ~(4'b0001 << row);
  endfunction

  function automatic bit debounce_on();
`ifdef STE_PAD_DEBOUNCE_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // driver tasks
  task automatic reset_pulse();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic wait_valid(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (valid === 1'b1) got = 1'b1;
    end
  endtask

  task automatic wait_sel(input logic [3:0] v, input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (sel === v) got = 1'b1;
    end
  endtask

  task automatic go_idle(input string who);
    bit ok;
    enable = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 3 * P && !ok; i++) begin
      @(negedge clk);
      if (busy === 1'b0) ok = 1'b1;
    end
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL %s_idle_timeout: busy=%b required 0", who, busy); end
  endtask

  // tests
  task automatic test_reset();
    reset_n = 1'b0;
    enable  = 1'b1;
    press   = 24'hFFFFFF;
    repeat (3) @(negedge clk);
    n_cmp++; if (sel !== 4'hF) begin n_bad++; $display("FAIL rst_sel: got %h required f", sel); end
    n_cmp++; if (matrix !== 24'h0) begin n_bad++; $display("FAIL rst_matrix: got %h required 0", matrix); end
    n_cmp++; if (joy !== 16'h0) begin n_bad++; $display("FAIL rst_joy: got %h required 0", joy); end
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b required 0", valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b required 0", busy); end
    enable  = 1'b0;
    press   = '0;
    reset_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || sel !== 4'hF) begin n_bad++; $display("FAIL rst_idle: busy=%b sel=%h required 0/f", busy, sel); end
  endtask

  task automatic test_walk();
    press  = '0;
    enable = 1'b1;
    @(negedge clk);
    for (int k = 0; k <= 2 * P; k++) begin
      n_cmp++; if (sel !== model_sel(k % P)) begin n_bad++; $display("FAIL walk_sel k=%0d: got %b required %b", k, sel, model_sel(k % P)); end
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL walk_busy k=%0d: got %b required 1", k, busy); end
      n_cmp++; if (valid !== (k == P || k == 2 * P)) begin n_bad++; $display("FAIL walk_valid k=%0d: got %b required %b", k, valid, (k == P || k == 2 * P)); end
      if (k == P) begin
        n_cmp++; if (joy !== 16'h0 || matrix !== 24'h0) begin n_bad++; $display("FAIL walk_data: joy=%h matrix=%h required 0/0", joy, matrix); end
      end
      @(negedge clk);
    end
    go_idle("walk");
  endtask

  task automatic scan_and_check(input string who, input logic [23:0] p, input logic [15:0] exp_joy);
    bit got;
    press  = p;
    enable = 1'b1;
    wait_valid(4 * P, got);
    n_cmp++; if (!got) begin n_bad++; $display("FAIL %s_valid_timeout: no valid, required one", who); end
    n_cmp++; if (matrix !== p) begin n_bad++; $display("FAIL %s_matrix: got %h required %h", who, matrix, p); end
    n_cmp++; if (joy !== exp_joy) begin n_bad++; $display("FAIL %s_joy: got %h required %h", who, joy, exp_joy); end
    go_idle(who);
  endtask

  task automatic test_single();
    scan_and_check("up", 24'h000001, 16'h0008);
  endtask

  task automatic test_combo();
    scan_and_check("option_key9", 24'h802000, 16'h0280);
  endtask

  task automatic test_random();
    logic [23:0] p;
    for (int i = 0; i < 8; i++) begin
      p = 24'($urandom());
      scan_and_check("random", p, model_joy(p));
    end
  endtask

  task automatic test_enable_drop();
    bit got;
    int n_valid, n_busy;
    logic [23:0] m_at_valid;
    enable = 1'b1;
    wait_sel(4'b1101, 3 * S, got);
    enable = 1'b0;
    n_cmp++; if (!got) begin n_bad++; $display("FAIL drop_row1_timeout: sel=%b required 1101", sel); end
    n_valid = 0; n_busy = 0; m_at_valid = '0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (valid === 1'b1) begin n_valid++; m_at_valid = matrix; end
      if (i >= 22 && busy !== 1'b0) n_busy++;
    end
    n_cmp++; if (n_valid != 1) begin n_bad++; $display("FAIL drop_valid_count: got %0d required 1", n_valid); end
    n_cmp++; if (m_at_valid !== press) begin n_bad++; $display("FAIL drop_matrix: got %h required %h", m_at_valid, press); end
    n_cmp++; if (n_busy != 0) begin n_bad++; $display("FAIL drop_busy_held: got %0d busy cycles required 0", n_busy); end
    n_cmp++; if (sel !== 4'hF) begin n_bad++; $display("FAIL drop_sel: got %h required f", sel); end
  endtask

  task automatic test_reset_mid();
    bit got;
    logic [23:0] p;
    p = 24'($urandom()) | 24'h000001;
    press  = p;
    enable = 1'b1;
    wait_sel(4'b1011, 4 * P, got);
    n_cmp++; if (!got) begin n_bad++; $display("FAIL midrst_row2_timeout: sel=%b required 1011", sel); end
    reset_n = 1'b0;
    #1;
    n_cmp++; if (sel !== 4'hF) begin n_bad++; $display("FAIL midrst_sel: got %h required f", sel); end
    n_cmp++; if (joy !== 16'h0) begin n_bad++; $display("FAIL midrst_joy: got %h required 0", joy); end
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL midrst_valid: got %b required 0", valid); end
    n_cmp++; if (busy !== 1'b0 || matrix !== 24'h0) begin n_bad++; $display("FAIL midrst_busy_matrix: busy=%b matrix=%h required 0/0", busy, matrix); end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (sel !== 4'b1110) begin n_bad++; $display("FAIL midrst_restart_sel: got %b required 1110", sel); end
    n_cmp++; if (matrix !== 24'h0) begin n_bad++; $display("FAIL midrst_partial: matrix=%h required 0", matrix); end
    wait_valid(4 * P, got);
    n_cmp++; if (!got) begin n_bad++; $display("FAIL midrst_valid_timeout: no valid, required one"); end
    n_cmp++; if (matrix !== p || joy !== model_joy(p)) begin n_bad++; $display("FAIL midrst_rescan: matrix=%h joy=%h required %h/%h", matrix, joy, p, model_joy(p)); end
    go_idle("midrst");
  endtask

  // pin11 alternates for six scans and is then held for two scans
  task automatic test_toggle();
    logic [23:0] scan_p [1:9];
    bit exp_v;
    int i;
    for (int s = 1; s <= 9; s++) scan_p[s] = (s > 6 || (s % 2) == 1) ? 24'h000001 : 24'h000000;
    reset_pulse();
    press  = scan_p[1];
    enable = 1'b1;
    @(negedge clk);
    for (int k = 0; k <= 8 * P; k++) begin
      i = k / P;
      exp_v = (k > 0) && (k % P == 0) && (!debounce_on() || i == 8);
      n_cmp++; if (valid !== exp_v) begin n_bad++; $display("FAIL toggle_valid k=%0d: got %b required %b", k, valid, exp_v); end
      if (exp_v) begin
        n_cmp++; if (joy !== model_joy(scan_p[i])) begin n_bad++; $display("FAIL toggle_joy scan=%0d: got %h required %h", i, joy, model_joy(scan_p[i])); end
      end
      if (k % P == 0) press = scan_p[i + 1];
      @(negedge clk);
    end
    n_cmp++; if (joy !== 16'h0008) begin n_bad++; $display("FAIL toggle_final_joy: got %h required 0008", joy); end
    go_idle("toggle");
  endtask

  // test sequence and final report
  initial begin
    n_cmp = 0; n_bad = 0;
    reset_n = 1'b0; enable = 1'b0; press = '0;
    test_reset();
    test_walk();
    test_single();
    test_combo();
    test_random();
    test_enable_drop();
    test_reset_mid();
    test_toggle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ste_joypad_scanner.md
STE_JOYPAD_SCANNER -- requirements
Module: ste_joypad_scanner

Interface
REQ-001 Parameter SETTLE, default 32, meaning: cycles each select row is driven before its sample; legal range 4..255.
REQ-002 clk  in  1  system clock; all state on rising edge.
REQ-003 reset_n  in  1  reset, asynchronous, active-low.
REQ-004 enable  in  1  scan request; high = scan continuously.
REQ-005 pad_data  in  4  port pins 11-14 (bit0=pin11), active-low, asynchronous to clk.
REQ-006 pad_btn  in  2  port pins 6,10 (bit0=pin6, bit1=pin10), active-low, asynchronous to clk.
REQ-007 sel  out  4  port pins 1-4 (bit0=pin1), active-low row selects.
REQ-008 matrix  out  24  last accepted raw scan, active-high; row r at bits [6r+5:6r] = {btn[1], btn[0], data[3:0]}.
REQ-009 joy  out  16  decoded pad state, active-high.
REQ-010 valid  out  1  one-cycle strobe when matrix/joy update.
REQ-011 busy  out  1  high while any row is driven or a scan is completing.

Function
REQ-012 pad_data and pad_btn SHALL pass through a 2-flop synchronizer, then be inverted to active-high before sampling.
REQ-013 FSM states: IDLE, ROW0, ROW1, ROW2, ROW3, DONE.
REQ-014 IDLE: sel=4'hF, busy=0; enable=1 -> ROW0 next cycle.
REQ-015 ROWn: sel has only bit n low; state lasts exactly SETTLE cycles; synchronized inputs sampled into a scan buffer on the last cycle; then ROWn+1 (ROW3 -> DONE).
REQ-016 DONE: one cycle, sel=4'hF; matrix/joy update per REQ-019/REQ-023; then ROW0 if enable=1, else IDLE.
REQ-017 Full scan period SHALL be 4*SETTLE+1 cycles; SETTLE=32 gives 129.
REQ-018 enable deasserted mid-scan: scan completes through DONE, then IDLE; no partial scan ever reaches matrix/joy.
REQ-019 On update, joy SHALL decode from the scan buffer: row0 data[0..3] -> joy[3],joy[2],joy[1],joy[0]; row0 btn1 -> joy[4]; row0 btn0 -> joy[13]; row1 data1 -> joy[12], data2 -> joy[10], btn1 -> joy[5]; row2 data1 -> joy[9], btn1 -> joy[6]; row3 data1 -> joy[8], data2 -> joy[11], btn1 -> joy[7]; joy[15:14]=0; all other matrix bits ignored for joy.
REQ-020 valid SHALL assert in the same cycle matrix/joy take new values, i.e. the cycle after DONE.
REQ-021 busy SHALL be 1 in ROW0..ROW3 and DONE, else 0.

Reset
REQ-022 reset_n low SHALL immediately force: state IDLE, sel=4'hF, matrix=0, joy=0, valid=0, busy=0, synchronizers and scan/previous buffers cleared; effective mid-scan with no partial update.

Configuration
REQ-023 Macro STE_PAD_DEBOUNCE_EN defined: on DONE, matrix/joy/valid update only if the scan buffer equals the previous full scan; the previous-scan register always takes the scan buffer at DONE. Undefined: matrix/joy update and valid pulses on every DONE; no previous-scan register.

Verification
REQ-024 Reset, enable=1, SETTLE=4, all pins high -> sel walks 1110,1101,1011,0111 (4 cycles each), 1 cycle 1111; valid pulse ~every 17 cycles; joy=0.
REQ-025 Model drives pin11 low only while sel=1110 -> joy=16'h0008 (up); matrix=24'h000001.
REQ-026 Model drives pin10 low only while sel=0111 and pin12 low while sel=1011 -> joy=16'h0280 (option + key 9).
REQ-027 enable dropped during ROW1 -> ROW2, ROW3, DONE complete, one valid, then sel=4'hF and busy=0 held.
REQ-028 reset_n pulsed low during ROW2 with pins active -> sel=4'hF, joy=0, valid=0 immediately; fresh scan restarts from ROW0.
REQ-029 With STE_PAD_DEBOUNCE_EN, pin11 toggled every scan -> no joy update/valid after first toggle; held two scans -> joy=16'h0008 with one valid; without macro each scan updates.
